// File: rtl/bullet_controller.sv
// Bullet slot manager: spawns, moves and retires player bullets once per frame.
// Optional macro BULLET_AUTOFIRE_EN: fire on level instead of rising edge.
module bullet_controller #(
    parameter int NUM_BULLETS     = 4,
    parameter int BULLET_SPEED    = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int PLAYER_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic                      fire,
    input  logic [9:0]                player_x,
    input  logic [9:0]                player_y,
    input  logic [NUM_BULLETS-1:0]    hit,
    output logic [10*NUM_BULLETS-1:0] bullet_x_flat,
    output logic [10*NUM_BULLETS-1:0] bullet_y_flat,
    output logic [NUM_BULLETS-1:0]    bullet_active,
    output logic                      shot
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [9:0]    SPD   = 10'(BULLET_SPEED);
    localparam logic [9:0]    X_OFF = 10'(PLAYER_W / 2 - 1);
    localparam logic [9:0]    Y_OFF = 10'd8;
    localparam logic [CW-1:0] CD    = CW'(COOLDOWN_FRAMES);

    logic [9:0]             r_x [NUM_BULLETS];
    logic [9:0]             r_y [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] r_active;
    logic [CW-1:0]          r_cool;
    logic                   r_shot;

    logic                   w_req;
    logic                   w_spawn;
    logic [NUM_BULLETS-1:0] w_free_oh;
    logic [9:0]             w_spawn_x;
    logic [9:0]             w_spawn_y;

`ifdef BULLET_AUTOFIRE_EN
    assign w_req = frame_tick & fire;
`else
    logic r_fire_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fire_prev <= 1'b0;
        end else if (frame_tick) begin
            r_fire_prev <= fire;
        end
    end

    assign w_req = frame_tick & fire & ~r_fire_prev;
`endif

    // isolate the lowest zero bit of the active mask
    always_comb begin
        w_free_oh = ~r_active & (r_active + NUM_BULLETS'(1));
        w_spawn   = w_req && (r_cool == '0) && (|(~r_active))
                    && (player_y >= Y_OFF);
        w_spawn_x = player_x + X_OFF;
        w_spawn_y = player_y - Y_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (w_spawn && w_free_oh[i]) begin
                    r_x[i]      <= w_spawn_x;
                    r_y[i]      <= w_spawn_y;
                    r_active[i] <= 1'b1;
                end else if (hit[i]) begin
                    r_active[i] <= 1'b0;
                end else if (frame_tick && r_active[i]) begin
                    if (r_y[i] >= SPD) begin
                        r_y[i] <= r_y[i] - SPD;
                    end else begin
                        r_active[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cool <= '0;
            r_shot <= 1'b0;
        end else begin
            r_shot <= w_spawn;
            if (w_spawn) begin
                r_cool <= CD;
            end else if (frame_tick && (r_cool != '0)) begin
                r_cool <= r_cool - CW'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_flat
        assign bullet_x_flat[10*g +: 10] = r_x[g];
        assign bullet_y_flat[10*g +: 10] = r_y[g];
    end

    assign bullet_active = r_active;
    assign shot          = r_shot;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller (default edge-triggered fire build).
module tb_bullet_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        fire = 1'b0;
    logic [9:0]  player_x = 10'd100;
    logic [9:0]  player_y = 10'd400;
    logic [3:0]  hit = 4'b0;
    logic [39:0] bullet_x_flat;
    logic [39:0] bullet_y_flat;
    logic [3:0]  bullet_active;
    logic        shot;

    int checks = 0;
    int failures = 0;
    int nshots;

    bullet_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .fire         (fire),
        .player_x     (player_x),
        .player_y     (player_y),
        .hit          (hit),
        .bullet_x_flat(bullet_x_flat),
        .bullet_y_flat(bullet_y_flat),
        .bullet_active(bullet_active),
        .shot         (shot)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] bx(input int i);
        return bullet_x_flat[10*i +: 10];
    endfunction

    function automatic logic [9:0] by(input int i);
        return bullet_y_flat[10*i +: 10];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic f);
        @(negedge clk);
        fire = f;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input logic f, input int n);
        for (int k = 0; k < n; k++) tick(f);
    endtask

    task automatic pulse_hit(input logic [3:0] v);
        @(negedge clk);
        hit = v;
        @(posedge clk);
        #1;
        hit = 4'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_active", bullet_active, 4'b0);
        chk("rst_x", bullet_x_flat, 40'd0);
        chk("rst_y", bullet_y_flat, 40'd0);
        chk("rst_shot", shot, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // first spawn
        tick(1'b1);
        chk("spawn_active", bullet_active, 4'b0001);
        chk("spawn_x", bx(0), 10'd115);
        chk("spawn_y", by(0), 10'd392);
        chk("spawn_shot", shot, 1'b1);
        @(posedge clk);
        #1;
        chk("shot_one_cycle", shot, 1'b0);

        // movement down to the top edge
        tick(1'b0);
        chk("move_y388", by(0), 10'd388);
        chk("move_noshot", shot, 1'b0);
        tick(1'b0);
        chk("move_y384", by(0), 10'd384);
        chk("move_x_hold", bx(0), 10'd115);
        ticks(1'b0, 96);
        chk("edge_y0", by(0), 10'd0);
        chk("edge_active", bullet_active, 4'b0001);
        tick(1'b0);
        chk("retire_active", bullet_active, 4'b0000);
        chk("retire_y_hold", by(0), 10'd0);

        // cooldown blocks re-fire until the ninth tick
        tick(1'b1);
        chk("cd_spawn0", bullet_active, 4'b0001);
        tick(1'b0);
        tick(1'b1);
        chk("cd_blocked_shot", shot, 1'b0);
        chk("cd_blocked_act", bullet_active, 4'b0001);
        ticks(1'b0, 6);
        tick(1'b1);
        chk("cd_spawn1_shot", shot, 1'b1);
        chk("cd_spawn1_act", bullet_active, 4'b0011);
        chk("cd_spawn1_y", by(1), 10'd392);
        chk("cd_slot0_y", by(0), 10'd356);

        // fill all slots, then a request with no free slot
        ticks(1'b0, 8);
        tick(1'b1);
        ticks(1'b0, 8);
        tick(1'b1);
        chk("full_active", bullet_active, 4'b1111);
        ticks(1'b0, 8);
        tick(1'b1);
        chk("full_noshot", shot, 1'b0);
        chk("full_active2", bullet_active, 4'b1111);
        pulse_hit(4'b0100);
        chk("hit2_active", bullet_active, 4'b1011);
        player_x = 10'd200;
        player_y = 10'd300;
        tick(1'b0);
        tick(1'b1);
        chk("refill_shot", shot, 1'b1);
        chk("refill_active", bullet_active, 4'b1111);
        chk("refill_x2", bx(2), 10'd215);
        chk("refill_y2", by(2), 10'd292);

        // hit together with movement tick
        @(negedge clk);
        fire = 1'b0;
        frame_tick = 1'b1;
        hit = 4'b0010;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        hit = 4'b0;
        chk("hitprio_active", bullet_active, 4'b1101);
        chk("hitprio_y1_hold", by(1), 10'd276);
        chk("hitprio_y0_move", by(0), 10'd236);

        // hit on inactive slot, then hit racing a spawn into slot 0
        pulse_hit(4'b0001);
        chk("hit0_active", bullet_active, 4'b1100);
        pulse_hit(4'b0010);
        chk("hit_inactive", bullet_active, 4'b1100);
        ticks(1'b0, 8);
        @(negedge clk);
        fire = 1'b1;
        frame_tick = 1'b1;
        hit = 4'b0001;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        hit = 4'b0;
        chk("race_active", bullet_active, 4'b1101);
        chk("race_x0", bx(0), 10'd215);
        chk("race_y0", by(0), 10'd292);
        chk("race_shot", shot, 1'b1);

        // held fire gives one shot only
        ticks(1'b0, 9);
        nshots = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b1);
            if (shot) nshots++;
        end
        chk("held_shots", nshots, 1);
        chk("held_slot1", bullet_active[1], 1'b1);

        // asynchronous reset mid-flight
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_active", bullet_active, 4'b0);
        chk("arst_x", bullet_x_flat, 40'd0);
        chk("arst_y", bullet_y_flat, 40'd0);
        chk("arst_shot", shot, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1);
        chk("post_rst_shot", shot, 1'b1);
        chk("post_rst_active", bullet_active, 4'b0001);
        chk("post_rst_x", bx(0), 10'd215);
        chk("post_rst_y", by(0), 10'd292);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bullet_controller.md
BULLET_CONTROLLER -- requirements
Module: bullet_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Clock and reset ports are clk and rst_n.
REQ-002 Parameter NUM_BULLETS, default 4: number of bullet slots.
REQ-003 Parameter BULLET_SPEED, default 4: pixels moved upward per frame.
REQ-004 Parameter COOLDOWN_FRAMES, default 8: minimum frames between two spawns.
REQ-005 Parameter PLAYER_W, default 32: player sprite width in pixels, used for centring.
REQ-006 Port clk, input, 1 bit: system clock.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port frame_tick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-009 Port fire, input, 1 bit: fire button level, synchronous to clk.
REQ-010 Port player_x, input, 10 bits: player sprite left edge.
REQ-011 Port player_y, input, 10 bits: player sprite top edge.
REQ-012 Port hit, input, NUM_BULLETS bits: a one-cycle pulse on bit i clears slot i.
REQ-013 Port bullet_x_flat, output, 10*NUM_BULLETS bits: bits [10i+9:10i] hold the x position of slot i.
REQ-014 Port bullet_y_flat, output, 10*NUM_BULLETS bits: same packing as bullet_x_flat, for y.
REQ-015 Port bullet_active, output, NUM_BULLETS bits: bit i high means slot i is visible.
REQ-016 Port shot, output, 1 bit: one-cycle pulse on every spawn.

Function
REQ-017 All outputs SHALL be registered; state changes SHALL occur only on rising clk edges.
REQ-018 Movement: on the frame_tick cycle, each slot that is active and not spawning SHALL set y to y-BULLET_SPEED if y >= BULLET_SPEED, and SHALL otherwise clear active (no wrap-around). x SHALL be unchanged.
REQ-019 Fire request: a request exists on the frame_tick cycle when the fire condition (REQ-033/034) is true.
REQ-020 Spawn condition: a request exists, cooldown == 0, at least one slot was inactive before the edge, and player_y >= 8.
REQ-021 On spawn, the lowest-index inactive slot SHALL load x = player_x + PLAYER_W/2 - 1 and y = player_y - 8, then set active.
REQ-022 On spawn, shot SHALL pulse for exactly that cycle, and cooldown SHALL load COOLDOWN_FRAMES.
REQ-023 A spawned bullet SHALL NOT move on its spawn tick.
REQ-024 If all slots are active, or player_y < 8, the request SHALL be dropped: no shot pulse, cooldown unchanged.
REQ-025 Cooldown: an internal counter of width clog2(COOLDOWN_FRAMES+1) SHALL decrement by 1 on each frame_tick while nonzero, and SHALL never be reloaded by anything except a spawn.
REQ-026 Hit: hit[i] SHALL clear active[i] in any cycle. Hit SHALL take priority over movement. Hit SHALL be ignored for the slot receiving a spawn in the same cycle.
REQ-027 Hit on an inactive slot SHALL have no effect.
REQ-028 x/y of inactive slots SHALL hold their last value; consumers gate on bullet_active.
REQ-029 Between frame_tick pulses, only hit SHALL change state.

Reset
REQ-030 On rst_n low, asynchronously: bullet_active = 0, all bullet_x_flat/bullet_y_flat = 0, shot = 0, cooldown = 0, fire edge register = 0.
REQ-031 Reset mid-flight SHALL discard all bullets. The first frame_tick after release with fire asserted SHALL spawn.
REQ-032 Release of rst_n SHALL be synchronous to clk (external synchroniser).

Configuration
REQ-033 With macro BULLET_AUTOFIRE_EN defined, the fire condition SHALL be fire high on the frame_tick cycle. Holding fire SHALL spawn every COOLDOWN_FRAMES+1 frames while slots are free.
REQ-034 Without BULLET_AUTOFIRE_EN, the fire condition SHALL be fire high on this frame_tick and low at the previous frame_tick (edge register updated on each frame_tick). Holding fire SHALL yield exactly one spawn.

Verification
REQ-035 Reset, then fire=1, player_x=100, player_y=400, one tick -> slot 0 active, x=115, y=392, shot pulses once.
REQ-036 Continue ticks with fire=0 -> slot 0 y=388, 384, ...; slot 0 clears on the tick where y < 4.
REQ-037 Fire on two consecutive ticks (autofire build) -> second tick gives no spawn (cooldown); spawn occurs on tick 9 after the first, into slot 1.
REQ-038 Four slots active plus a spawn-eligible request -> no shot, cooldown stays 0; then hit[2] pulse -> slot 2 inactive; next request -> spawn into slot 2.
REQ-039 hit[0] asserted on the same cycle a spawn targets slot 0 -> slot 0 active at the spawn position.
REQ-040 Non-autofire build, fire held for 20 ticks -> exactly one spawn; rst_n pulsed mid-flight -> all outputs 0 immediately.
